// File: rtl/salu_exec_state_file.sv
// Per-wavefront scalar state (EXEC, VCC, M0, SCC) serving salu reads/writes, VALU VCC writes
// and dispatcher init. Optional sticky collision flag under EXEC_STATE_CONFLICT_DET_EN.
module salu_exec_state_file #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_rd_en,
  input  logic [WFID_W-1:0] exec_rd_wfid,
  output logic [63:0]       exec_rd_exec_value,
  output logic [63:0]       exec_rd_vcc_value,
  output logic [31:0]       exec_rd_m0_value,
  output logic              exec_rd_scc_value,
  output logic              exec_rd_execz,
  output logic              exec_rd_vccz,
  output logic              exec_rd_valid,
  input  logic              exec_wr_exec_en,
  input  logic              exec_wr_vcc_en,
  input  logic              exec_wr_m0_en,
  input  logic              exec_wr_scc_en,
  input  logic [63:0]       exec_wr_exec_value,
  input  logic [63:0]       exec_wr_vcc_value,
  input  logic [31:0]       exec_wr_m0_value,
  input  logic              exec_wr_scc_value,
  input  logic [WFID_W-1:0] exec_wr_wfid,
  input  logic              valu_vcc_wr_en,
  input  logic [WFID_W-1:0] valu_vcc_wr_wfid,
  input  logic [63:0]       valu_vcc_wr_value,
  input  logic [63:0]       valu_vcc_wr_mask,
  input  logic              dispatch_init_en,
  input  logic [WFID_W-1:0] dispatch_init_wfid,
  input  logic [63:0]       dispatch_init_exec
`ifdef EXEC_STATE_CONFLICT_DET_EN
  ,
  output logic              conflict_err
`endif
);

  logic [63:0] exec_q [NUM_WF];
  logic [63:0] vcc_q  [NUM_WF];
  logic [31:0] m0_q   [NUM_WF];
  logic        scc_q  [NUM_WF];

  logic [NUM_WF-1:0] init_hit, salu_hit, valu_hit;

  function automatic logic [63:0] lane_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [63:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Per-slot decode; only in-range ids can ever match, so out-of-range writes fall away here.
  always_comb begin
    init_hit = '0;
    salu_hit = '0;
    valu_hit = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      init_hit[w] = dispatch_init_en && (dispatch_init_wfid == WFID_W'(w));
      salu_hit[w] = (exec_wr_wfid == WFID_W'(w));
      valu_hit[w] = valu_vcc_wr_en && (valu_vcc_wr_wfid == WFID_W'(w));
    end
  end

  // Later assignments win: VALU, then salu, then dispatch init.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WF; w++) begin
      if (rst) begin
        exec_q[w] <= '0;
        vcc_q[w]  <= '0;
        m0_q[w]   <= '0;
        scc_q[w]  <= 1'b0;
      end else begin
        if (valu_hit[w]) vcc_q[w] <= lane_merge(vcc_q[w], valu_vcc_wr_value, valu_vcc_wr_mask);
        if (salu_hit[w]) begin
          if (exec_wr_exec_en) exec_q[w] <= exec_wr_exec_value;
          if (exec_wr_vcc_en)  vcc_q[w]  <= exec_wr_vcc_value;
          if (exec_wr_m0_en)   m0_q[w]   <= exec_wr_m0_value;
          if (exec_wr_scc_en)  scc_q[w]  <= exec_wr_scc_value;
        end
        if (init_hit[w]) begin
          exec_q[w] <= dispatch_init_exec;
          vcc_q[w]  <= '0;
          m0_q[w]   <= '0;
          scc_q[w]  <= 1'b0;
        end
      end
    end
  end

  logic              rd_in_range;
  logic [WFID_W-1:0] rd_idx;
  logic [63:0]       exec_byp, vcc_byp;
  logic [31:0]       m0_byp;
  logic              scc_byp;

  assign rd_in_range = (exec_rd_wfid < WFID_W'(NUM_WF));
  assign rd_idx      = rd_in_range ? exec_rd_wfid : '0;

  // Bypass: mirror the write priority so the read sees the post-write state of its slot.
  always_comb begin
    exec_byp = exec_q[rd_idx];
    vcc_byp  = vcc_q[rd_idx];
    m0_byp   = m0_q[rd_idx];
    scc_byp  = scc_q[rd_idx];
    if (valu_vcc_wr_en && (valu_vcc_wr_wfid == exec_rd_wfid))
      vcc_byp = lane_merge(vcc_byp, valu_vcc_wr_value, valu_vcc_wr_mask);
    if (exec_wr_wfid == exec_rd_wfid) begin
      if (exec_wr_exec_en) exec_byp = exec_wr_exec_value;
      if (exec_wr_vcc_en)  vcc_byp  = exec_wr_vcc_value;
      if (exec_wr_m0_en)   m0_byp   = exec_wr_m0_value;
      if (exec_wr_scc_en)  scc_byp  = exec_wr_scc_value;
    end
    if (dispatch_init_en && (dispatch_init_wfid == exec_rd_wfid)) begin
      exec_byp = dispatch_init_exec;
      vcc_byp  = '0;
      m0_byp   = '0;
      scc_byp  = 1'b0;
    end
    if (!rd_in_range) begin
      exec_byp = '0;
      vcc_byp  = '0;
      m0_byp   = '0;
      scc_byp  = 1'b0;
    end
  end

  // ---- stage p1: registered read response ----
  logic [63:0] exec_p1, vcc_p1;
  logic [31:0] m0_p1;
  logic        scc_p1, execz_p1, vccz_p1, vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      exec_p1  <= '0;
      vcc_p1   <= '0;
      m0_p1    <= '0;
      scc_p1   <= 1'b0;
      execz_p1 <= 1'b0;
      vccz_p1  <= 1'b0;
    end else begin
      vld_p1 <= exec_rd_en;
      if (exec_rd_en) begin
        exec_p1  <= exec_byp;
        vcc_p1   <= vcc_byp;
        m0_p1    <= m0_byp;
        scc_p1   <= scc_byp;
        execz_p1 <= (exec_byp == 64'd0);
        vccz_p1  <= (vcc_byp == 64'd0);
      end
    end
  end

  assign exec_rd_exec_value = exec_p1;
  assign exec_rd_vcc_value  = vcc_p1;
  assign exec_rd_m0_value   = m0_p1;
  assign exec_rd_scc_value  = scc_p1;
  assign exec_rd_execz      = execz_p1;
  assign exec_rd_vccz       = vccz_p1;
  assign exec_rd_valid      = vld_p1;

`ifdef EXEC_STATE_CONFLICT_DET_EN
  logic salu_any_en, collision;
  logic conflict_q;

  assign salu_any_en = exec_wr_exec_en | exec_wr_vcc_en | exec_wr_m0_en | exec_wr_scc_en;
  assign collision   = (|(salu_hit & valu_hit & {NUM_WF{exec_wr_vcc_en}}))
                     | (|(init_hit & ((salu_hit & {NUM_WF{salu_any_en}}) | valu_hit)));

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict_q | collision;
  end

  assign conflict_err = conflict_q;
`endif

endmodule

// File: tb/tb_salu_exec_state_file.sv
// Directed self-checking bench for salu_exec_state_file with hand-computed expected values.
module tb_salu_exec_state_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        exec_rd_en;
  logic [5:0]  exec_rd_wfid;
  logic [63:0] exec_rd_exec_value, exec_rd_vcc_value;
  logic [31:0] exec_rd_m0_value;
  logic        exec_rd_scc_value, exec_rd_execz, exec_rd_vccz, exec_rd_valid;
  logic        exec_wr_exec_en, exec_wr_vcc_en, exec_wr_m0_en, exec_wr_scc_en;
  logic [63:0] exec_wr_exec_value, exec_wr_vcc_value;
  logic [31:0] exec_wr_m0_value;
  logic        exec_wr_scc_value;
  logic [5:0]  exec_wr_wfid;
  logic        valu_vcc_wr_en;
  logic [5:0]  valu_vcc_wr_wfid;
  logic [63:0] valu_vcc_wr_value, valu_vcc_wr_mask;
  logic        dispatch_init_en;
  logic [5:0]  dispatch_init_wfid;
  logic [63:0] dispatch_init_exec;
`ifdef EXEC_STATE_CONFLICT_DET_EN
  logic        conflict_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  salu_exec_state_file #(.NUM_WF(40), .WFID_W(6)) dut (
    .clk(clk), .rst(rst),
    .exec_rd_en(exec_rd_en), .exec_rd_wfid(exec_rd_wfid),
    .exec_rd_exec_value(exec_rd_exec_value), .exec_rd_vcc_value(exec_rd_vcc_value),
    .exec_rd_m0_value(exec_rd_m0_value), .exec_rd_scc_value(exec_rd_scc_value),
    .exec_rd_execz(exec_rd_execz), .exec_rd_vccz(exec_rd_vccz), .exec_rd_valid(exec_rd_valid),
    .exec_wr_exec_en(exec_wr_exec_en), .exec_wr_vcc_en(exec_wr_vcc_en),
    .exec_wr_m0_en(exec_wr_m0_en), .exec_wr_scc_en(exec_wr_scc_en),
    .exec_wr_exec_value(exec_wr_exec_value), .exec_wr_vcc_value(exec_wr_vcc_value),
    .exec_wr_m0_value(exec_wr_m0_value), .exec_wr_scc_value(exec_wr_scc_value),
    .exec_wr_wfid(exec_wr_wfid),
    .valu_vcc_wr_en(valu_vcc_wr_en), .valu_vcc_wr_wfid(valu_vcc_wr_wfid),
    .valu_vcc_wr_value(valu_vcc_wr_value), .valu_vcc_wr_mask(valu_vcc_wr_mask),
    .dispatch_init_en(dispatch_init_en), .dispatch_init_wfid(dispatch_init_wfid),
    .dispatch_init_exec(dispatch_init_exec)
`ifdef EXEC_STATE_CONFLICT_DET_EN
    , .conflict_err(conflict_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; exec_rd_en = 1'b0; exec_rd_wfid = '0;
    exec_wr_exec_en = 1'b0; exec_wr_vcc_en = 1'b0; exec_wr_m0_en = 1'b0; exec_wr_scc_en = 1'b0;
    exec_wr_exec_value = '0; exec_wr_vcc_value = '0; exec_wr_m0_value = '0;
    exec_wr_scc_value = 1'b0; exec_wr_wfid = '0;
    valu_vcc_wr_en = 1'b0; valu_vcc_wr_wfid = '0; valu_vcc_wr_value = '0; valu_vcc_wr_mask = '0;
    dispatch_init_en = 1'b0; dispatch_init_wfid = '0; dispatch_init_exec = '0;
  endtask

  // Advance one clock and settle 1 time unit after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic [5:0] wfid);
    idle();
    exec_rd_en = 1'b1; exec_rd_wfid = wfid;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_valid", exec_rd_valid, 0);
    check("rst_exec", exec_rd_exec_value, 0);
    check("rst_vcc", exec_rd_vcc_value, 0);
    check("rst_m0", exec_rd_m0_value, 0);
`ifdef EXEC_STATE_CONFLICT_DET_EN
    check("rst_conflict", conflict_err, 0);
`endif
    idle();
    tick();

    read(6'd5);
    check("rd5_valid", exec_rd_valid, 1);
    check("rd5_exec", exec_rd_exec_value, 0);
    check("rd5_vcc", exec_rd_vcc_value, 0);
    check("rd5_execz", exec_rd_execz, 1);
    check("rd5_vccz", exec_rd_vccz, 1);
    tick();
    check("idle_valid", exec_rd_valid, 0);

    dispatch_init_en = 1'b1; dispatch_init_wfid = 6'd2; dispatch_init_exec = 64'h8888888844444444;
    tick();
    read(6'd2);
    check("init_exec", exec_rd_exec_value, 64'h8888888844444444);
    check("init_execz", exec_rd_execz, 0);
    check("init_m0", exec_rd_m0_value, 0);
    check("init_scc", exec_rd_scc_value, 0);

    exec_wr_vcc_en = 1'b1; exec_wr_wfid = 6'd2; exec_wr_vcc_value = 64'h2222222211111111;
    exec_rd_en = 1'b1; exec_rd_wfid = 6'd2;
    tick();
    idle();
    check("byp_vcc", exec_rd_vcc_value, 64'h2222222211111111);
    check("byp_vccz", exec_rd_vccz, 0);
    check("byp_exec", exec_rd_exec_value, 64'h8888888844444444);
    tick();
    check("hold_valid", exec_rd_valid, 0);
    check("hold_vcc", exec_rd_vcc_value, 64'h2222222211111111);

    valu_vcc_wr_en = 1'b1; valu_vcc_wr_wfid = 6'd3;
    valu_vcc_wr_value = '1; valu_vcc_wr_mask = 64'h00000000FFFFFFFF;
    tick();
    read(6'd3);
    check("valu_vcc", exec_rd_vcc_value, 64'h00000000FFFFFFFF);
    valu_vcc_wr_en = 1'b1; valu_vcc_wr_wfid = 6'd3;
    valu_vcc_wr_value = '0; valu_vcc_wr_mask = 64'h000000000000000F;
    exec_rd_en = 1'b1; exec_rd_wfid = 6'd3;
    tick();
    idle();
    check("valu_byp_vcc", exec_rd_vcc_value, 64'h00000000FFFFFFF0);

`ifdef EXEC_STATE_CONFLICT_DET_EN
    check("pre_conflict", conflict_err, 0);
`endif
    exec_wr_vcc_en = 1'b1; exec_wr_wfid = 6'd4; exec_wr_vcc_value = '0;
    valu_vcc_wr_en = 1'b1; valu_vcc_wr_wfid = 6'd4; valu_vcc_wr_value = '1; valu_vcc_wr_mask = '1;
    tick();
    idle();
`ifdef EXEC_STATE_CONFLICT_DET_EN
    check("conflict_set", conflict_err, 1);
`endif
    read(6'd4);
    check("prio_vcc", exec_rd_vcc_value, 0);
    check("prio_vccz", exec_rd_vccz, 1);
`ifdef EXEC_STATE_CONFLICT_DET_EN
    check("conflict_sticky", conflict_err, 1);
`endif

    exec_wr_m0_en = 1'b1; exec_wr_wfid = 6'd45; exec_wr_m0_value = 32'h1234;
    exec_wr_exec_en = 1'b1; exec_wr_exec_value = 64'hFF;
    tick();
    read(6'd45);
    check("oor_valid", exec_rd_valid, 1);
    check("oor_m0", exec_rd_m0_value, 0);
    check("oor_exec", exec_rd_exec_value, 0);
    check("oor_execz", exec_rd_execz, 1);
    check("oor_vccz", exec_rd_vccz, 1);
    read(6'd13);
    check("alias13_m0", exec_rd_m0_value, 0);
    check("alias13_exec", exec_rd_exec_value, 0);
    read(6'd39);
    check("slot39_m0", exec_rd_m0_value, 0);

    dispatch_init_en = 1'b1; dispatch_init_wfid = 6'd6; dispatch_init_exec = 64'h1;
    exec_wr_exec_en = 1'b1; exec_wr_m0_en = 1'b1; exec_wr_wfid = 6'd6;
    exec_wr_exec_value = 64'hFF; exec_wr_m0_value = 32'h55;
    exec_rd_en = 1'b1; exec_rd_wfid = 6'd6;
    tick();
    idle();
    check("init_prio_byp_exec", exec_rd_exec_value, 64'h1);
    check("init_prio_byp_m0", exec_rd_m0_value, 0);
    read(6'd6);
    check("init_prio_exec", exec_rd_exec_value, 64'h1);
    check("init_prio_m0", exec_rd_m0_value, 0);

    exec_wr_exec_en = 1'b1; exec_wr_vcc_en = 1'b1; exec_wr_m0_en = 1'b1; exec_wr_scc_en = 1'b1;
    exec_wr_wfid = 6'd7; exec_wr_exec_value = 64'hA5A5; exec_wr_vcc_value = 64'h5A5A0000;
    exec_wr_m0_value = 32'hDEADBEEF; exec_wr_scc_value = 1'b1;
    tick();
    read(6'd7);
    check("multi_exec", exec_rd_exec_value, 64'hA5A5);
    check("multi_vcc", exec_rd_vcc_value, 64'h5A5A0000);
    check("multi_m0", exec_rd_m0_value, 32'hDEADBEEF);
    check("multi_scc", exec_rd_scc_value, 1);

    exec_wr_vcc_en = 1'b1; exec_wr_wfid = 6'd8; exec_wr_vcc_value = 64'h77;
    valu_vcc_wr_en = 1'b1; valu_vcc_wr_wfid = 6'd9; valu_vcc_wr_value = '1; valu_vcc_wr_mask = 64'hF0;
    tick();
    read(6'd8);
    check("diff_slot8_vcc", exec_rd_vcc_value, 64'h77);
    read(6'd9);
    check("diff_slot9_vcc", exec_rd_vcc_value, 64'hF0);

    rst = 1'b1; exec_rd_en = 1'b1; exec_rd_wfid = 6'd7;
    tick();
    idle();
    check("midrst_valid", exec_rd_valid, 0);
    check("midrst_exec", exec_rd_exec_value, 0);
`ifdef EXEC_STATE_CONFLICT_DET_EN
    check("midrst_conflict", conflict_err, 0);
`endif
    read(6'd7);
    check("midrst_slot7_m0", exec_rd_m0_value, 0);
    check("midrst_slot7_scc", exec_rd_scc_value, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
